// File: rtl/viterbi_ber_ctrl.sv
`timescale 1ns/1ps
// viterbi_ber_ctrl
// Test sequencer for the encoder / channel / Viterbi loop. Drives a PRBS-7
// payload followed by a zero tail into the encoder and schedules periodic
// burst bit flips for the channel. It also checks decoded bits against a
// latency-matched copy of the source and counts flipped code bits and
// residual payload errors.
//
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   start_i            start a run (ignored unless idle)
//   err_period_i       encoder cycles between burst starts, 0 = no injection
//   err_burst_i        burst length in encoder cycles, 0 behaves as 1
//   err_mask_i         code-bit flip mask used during burst cycles
//   dec_data_i         decoded bit, DEC_LAT cycles after its encoder bit
//   enc_en_o           encoder enable
//   enc_data_o         encoder input bit
//   err_inj_o          channel flip mask, aligned with enc_en_o
//   busy_o             run in progress
//   done_o             one-cycle pulse at run end
//   inj_ct_o           saturating count of flipped code bits
//   bit_err_ct_o       saturating count of payload bit errors
//
// state   | meaning
// S_IDLE  | waiting for start_i
// S_RUN   | FRAME_LEN PRBS payload bits into the encoder
// S_FLUSH | TAIL zero bits to flush the encoder
// S_DRAIN | DEC_LAT idle cycles so the last bits reach the comparator
// S_DONE  | one-cycle done_o pulse

module viterbi_ber_ctrl #(
    parameter int FRAME_LEN = 256,
    parameter int TAIL      = 8,
    parameter int DEC_LAT   = 16,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [7:0]    err_period_i,
    input  logic [2:0]    err_burst_i,
    input  logic [1:0]    err_mask_i,
    input  logic          dec_data_i,
    output logic          enc_en_o,
    output logic          enc_data_o,
    output logic [1:0]    err_inj_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [CW-1:0] inj_ct_o,
    output logic [CW-1:0] bit_err_ct_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int MAX_A   = (FRAME_LEN > TAIL) ? FRAME_LEN : TAIL;
    localparam int MAX_LEN = (MAX_A > DEC_LAT) ? MAX_A : DEC_LAT;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);
    localparam logic [6:0] LFSR_SEED = 7'h7F;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [6:0]         r_lfsr;
    logic               r_tag;
    logic [7:0]         r_period;
    logic [2:0]         r_burst;
    logic [1:0]         r_mask;
    logic [7:0]         r_pcnt;
    logic [2:0]         r_rem;
    logic [DEC_LAT-1:0] r_ref_bit;
    logic [DEC_LAT-1:0] r_ref_tag;

    logic       w_start;
    logic       w_en_next;
    logic [7:0] w_period;
    logic [2:0] w_burst;
    logic [1:0] w_mask;
    logic [7:0] w_pcnt;
    logic [2:0] w_rem;
    logic [2:0] w_burst_eff;
    logic       w_trig;
    logic       w_inj_act;
    logic [1:0] w_inj_next;
    logic [CW:0] w_inj_sum;
    logic       w_bit_err;

    // Scheduler decisions are made one cycle ahead so err_inj_o is registered
    // alongside the enc_en_o/enc_data_o it belongs to. On the start edge the
    // freshly presented settings and a cleared period counter are used.
    assign w_start     = (r_state == S_IDLE) && start_i;
    assign w_en_next   = w_start || (r_state == S_RUN) ||
                         ((r_state == S_FLUSH) && (r_cnt != '0));
    assign w_period    = w_start ? err_period_i : r_period;
    assign w_burst     = w_start ? err_burst_i  : r_burst;
    assign w_mask      = w_start ? err_mask_i   : r_mask;
    assign w_pcnt      = w_start ? 8'd0 : r_pcnt;
    assign w_rem       = w_start ? 3'd0 : r_rem;
    assign w_burst_eff = (w_burst == 3'd0) ? 3'd1 : w_burst;
    assign w_trig      = (w_pcnt == (w_period - 8'd1));
    assign w_inj_act   = w_en_next && (w_period != 8'd0);
    assign w_inj_next  = (w_inj_act && (w_trig || (w_rem != 3'd0))) ? w_mask : 2'b00;

    assign w_inj_sum = {1'b0, inj_ct_o} +
                       (CW+1)'({1'b0, err_inj_o[1]} + {1'b0, err_inj_o[0]});
    assign w_bit_err = r_ref_tag[DEC_LAT-1] && (dec_data_i ^ r_ref_bit[DEC_LAT-1]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_lfsr     <= LFSR_SEED;
            r_tag      <= 1'b0;
            r_period   <= 8'd0;
            r_burst    <= 3'd0;
            r_mask     <= 2'b00;
            enc_en_o   <= 1'b0;
            enc_data_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            enc_en_o <= w_en_next;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_state    <= S_RUN;
                        r_cnt      <= CNT_W'(FRAME_LEN - 1);
                        r_period   <= err_period_i;
                        r_burst    <= err_burst_i;
                        r_mask     <= err_mask_i;
                        enc_data_o <= LFSR_SEED[6];
                        r_lfsr     <= {LFSR_SEED[5:0], LFSR_SEED[6] ^ LFSR_SEED[5]};
                        r_tag      <= 1'b1;
                        busy_o     <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (r_cnt == '0) begin
                        r_state    <= S_FLUSH;
                        r_cnt      <= CNT_W'(TAIL - 1);
                        enc_data_o <= 1'b0;
                        r_tag      <= 1'b0;
                    end else begin
                        r_cnt      <= r_cnt - CNT_W'(1);
                        enc_data_o <= r_lfsr[6];
                        r_lfsr     <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
                    end
                end
                S_FLUSH: begin
                    if (r_cnt == '0) begin
                        r_state <= S_DRAIN;
                        r_cnt   <= CNT_W'(DEC_LAT - 1);
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    done_o  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Burst scheduler. A trigger restarts the burst rather than extending it;
    // leaving the enable window (DRAIN/IDLE) drops any unfinished burst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pcnt    <= 8'd0;
            r_rem     <= 3'd0;
            err_inj_o <= 2'b00;
        end else begin
            err_inj_o <= w_inj_next;
            if (w_inj_act) begin
                r_pcnt <= w_trig ? 8'd0 : (w_pcnt + 8'd1);
                if (w_trig) begin
                    r_rem <= w_burst_eff - 3'd1;
                end else if (w_rem != 3'd0) begin
                    r_rem <= w_rem - 3'd1;
                end else begin
                    r_rem <= 3'd0;
                end
            end else if (w_start || !w_en_next) begin
                r_pcnt <= 8'd0;
                r_rem  <= 3'd0;
            end
        end
    end

    // Reference delay line: the entry leaving it lines up with dec_data_i.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ref_bit <= '0;
            r_ref_tag <= '0;
        end else begin
            r_ref_bit[0] <= enc_data_o;
            r_ref_tag[0] <= r_tag;
            for (int i = 1; i < DEC_LAT; i++) begin
                r_ref_bit[i] <= r_ref_bit[i-1];
                r_ref_tag[i] <= r_ref_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inj_ct_o     <= '0;
            bit_err_ct_o <= '0;
        end else if (w_start) begin
            inj_ct_o     <= '0;
            bit_err_ct_o <= '0;
        end else begin
            inj_ct_o <= w_inj_sum[CW] ? {CW{1'b1}} : w_inj_sum[CW-1:0];
            if (w_bit_err && !(&bit_err_ct_o)) begin
                bit_err_ct_o <= bit_err_ct_o + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_viterbi_ber_ctrl.sv
`timescale 1ns/1ps
module tb_viterbi_ber_ctrl;

    localparam int DEC_LAT = 16;
    localparam int N_ENC   = 264;
    localparam int DONE_AT = 281;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [7:0]  err_period_i;
    logic [2:0]  err_burst_i;
    logic [1:0]  err_mask_i;
    logic        dec_data_i;
    logic        enc_en_o;
    logic        enc_data_o;
    logic [1:0]  err_inj_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] inj_ct_o;
    logic [15:0] bit_err_ct_o;

    logic        s_start;
    logic [7:0]  s_period;
    logic [2:0]  s_burst;
    logic [1:0]  s_mask;
    logic        s_dec;
    logic        s_en;
    logic        s_data;
    logic [1:0]  s_inj;
    logic        s_busy;
    logic        s_done;
    logic [3:0]  s_inj_ct;
    logic [3:0]  s_bit_err;

    viterbi_ber_ctrl u_dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .err_period_i(err_period_i), .err_burst_i(err_burst_i), .err_mask_i(err_mask_i),
        .dec_data_i(dec_data_i), .enc_en_o(enc_en_o), .enc_data_o(enc_data_o),
        .err_inj_o(err_inj_o), .busy_o(busy_o), .done_o(done_o),
        .inj_ct_o(inj_ct_o), .bit_err_ct_o(bit_err_ct_o)
    );

    viterbi_ber_ctrl #(.CW(4)) u_sat (
        .clk(clk), .rst(rst), .start_i(s_start),
        .err_period_i(s_period), .err_burst_i(s_burst), .err_mask_i(s_mask),
        .dec_data_i(s_dec), .enc_en_o(s_en), .enc_data_o(s_data),
        .err_inj_o(s_inj), .busy_o(s_busy), .done_o(s_done),
        .inj_ct_o(s_inj_ct), .bit_err_ct_o(s_bit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int mon_cyc, mon_idx, mon_done_cnt, mon_done_cyc, mon_noen_inj;
    logic [1:0] mon_inj  [0:299];
    logic       mon_data [0:299];
    logic       hist_bit [0:DEC_LAT];
    int         hist_idx [0:DEC_LAT];
    int inv0 = -1, inv1 = -1, inv2 = -1;

    // Monitor and decoder model: dec_data_i replays enc_data_o DEC_LAT cycles
    // later, optionally inverting selected encoder bit indices.
    initial begin
        dec_data_i = 1'b0;
        for (int i = 0; i <= DEC_LAT; i++) begin
            hist_bit[i] = 1'b0;
            hist_idx[i] = -1;
        end
        forever begin
            @(posedge clk);
            #1;
            mon_cyc++;
            for (int i = DEC_LAT; i > 0; i--) begin
                hist_bit[i] = hist_bit[i-1];
                hist_idx[i] = hist_idx[i-1];
            end
            hist_bit[0] = enc_data_o;
            hist_idx[0] = enc_en_o ? mon_idx : -1;
            if (enc_en_o) begin
                if (mon_idx < 300) begin
                    mon_inj[mon_idx]  = err_inj_o;
                    mon_data[mon_idx] = enc_data_o;
                end
                mon_idx++;
            end else if (err_inj_o != 2'b00) begin
                mon_noen_inj++;
            end
            if (done_o) begin
                mon_done_cnt++;
                mon_done_cyc = mon_cyc;
            end
            dec_data_i = hist_bit[DEC_LAT] ^
                ((hist_idx[DEC_LAT] >= 0) &&
                 (hist_idx[DEC_LAT] == inv0 || hist_idx[DEC_LAT] == inv1 ||
                  hist_idx[DEC_LAT] == inv2));
        end
    end

    task automatic start_run(input logic [7:0] per, input logic [2:0] bur, input logic [1:0] msk);
        @(negedge clk);
        err_period_i = per;
        err_burst_i  = bur;
        err_mask_i   = msk;
        start_i      = 1'b1;
        mon_cyc = 0; mon_idx = 0; mon_done_cnt = 0; mon_done_cyc = 0; mon_noen_inj = 0;
        for (int i = 0; i < 300; i++) begin
            mon_inj[i]  = 2'b00;
            mon_data[i] = 1'b0;
        end
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (mon_done_cnt == 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        n_tests++;
        if (mon_done_cnt == 0) begin
            n_fail++;
            $display("FAIL %s_timeout: no done_o within %0d cycles, required within %0d", name, t, DONE_AT);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic prbs_mismatch(output int mism);
        logic [6:0] l;
        l = 7'h7F;
        mism = 0;
        for (int i = 0; i < N_ENC; i++) begin
            if (i < 256) begin
                if (mon_data[i] !== l[6]) mism++;
                l = {l[5:0], l[6] ^ l[5]};
            end else if (mon_data[i] !== 1'b0) begin
                mism++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        start_i = 1'b0; err_period_i = 8'd0; err_burst_i = 3'd0; err_mask_i = 2'b00;
        s_start = 1'b0; s_period = 8'd0; s_burst = 3'd0; s_mask = 2'b00; s_dec = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({enc_en_o, enc_data_o, err_inj_o, busy_o, done_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 000000", {enc_en_o, enc_data_o, err_inj_o, busy_o, done_o});
        end
        n_tests++;
        if (inj_ct_o !== 16'd0 || bit_err_ct_o !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got inj=%0d err=%0d required 0 0", inj_ct_o, bit_err_ct_o);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy_o !== 1'b0 || enc_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b en=%b required 0 0", busy_o, enc_en_o);
        end
    endtask

    task automatic test_no_inject;
        int mism;
        logic [6:0] first7;
        start_run(8'd0, 3'd0, 2'b00);
        n_tests++;
        if (busy_o !== 1'b1 || enc_en_o !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_at_start: busy=%b en=%b required 1 1", busy_o, enc_en_o);
        end
        wait_done("no_inj");
        n_tests++;
        if (mon_idx !== N_ENC) begin
            n_fail++;
            $display("FAIL enc_cycles: got %0d required %0d", mon_idx, N_ENC);
        end
        n_tests++;
        if (mon_done_cnt !== 1 || mon_done_cyc !== DONE_AT) begin
            n_fail++;
            $display("FAIL done_timing: count=%0d cycle=%0d required 1 at %0d", mon_done_cnt, mon_done_cyc, DONE_AT);
        end
        n_tests++;
        if (inj_ct_o !== 16'd0 || bit_err_ct_o !== 16'd0) begin
            n_fail++;
            $display("FAIL clean_counts: inj=%0d err=%0d required 0 0", inj_ct_o, bit_err_ct_o);
        end
        prbs_mismatch(mism);
        n_tests++;
        if (mism !== 0) begin
            n_fail++;
            $display("FAIL prbs_stream: %0d bad bits, required 0", mism);
        end
        first7 = {mon_data[0], mon_data[1], mon_data[2], mon_data[3], mon_data[4], mon_data[5], mon_data[6]};
        n_tests++;
        if (first7 !== 7'h7F || mon_data[7] !== 1'b0) begin
            n_fail++;
            $display("FAIL prbs_head: got %b,%b required 1111111,0", first7, mon_data[7]);
        end
        repeat (10) @(negedge clk);
        n_tests++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || mon_done_cnt !== 1) begin
            n_fail++;
            $display("FAIL idle_after_done: busy=%b done=%b pulses=%0d required 0 0 1", busy_o, done_o, mon_done_cnt);
        end
    endtask

    task automatic test_inject(input string name, input logic [7:0] per, input logic [2:0] bur,
                               input logic [1:0] msk, input int mode, input int exp_ct);
        int mism;
        logic [1:0] e;
        start_run(per, bur, msk);
        wait_done(name);
        mism = 0;
        for (int i = 0; i < N_ENC; i++) begin
            case (mode)
                0: e = (i % 16 == 15) ? msk : 2'b00;
                1: e = ((i % 16 == 15) || (i % 16 == 0 && i > 0)) ? msk : 2'b00;
                default: e = (i >= 1) ? msk : 2'b00;
            endcase
            if (mon_inj[i] !== e) mism++;
        end
        n_tests++;
        if (mism !== 0) begin
            n_fail++;
            $display("FAIL %s_pattern: %0d cycles wrong, required 0", name, mism);
        end
        n_tests++;
        if (inj_ct_o !== exp_ct[15:0] || mon_noen_inj !== 0) begin
            n_fail++;
            $display("FAIL %s_count: inj=%0d noen=%0d required %0d 0", name, inj_ct_o, mon_noen_inj, exp_ct);
        end
    endtask

    task automatic test_bit_err;
        start_run(8'd0, 3'd0, 2'b00);
        inv0 = 0; inv1 = 100; inv2 = 260;
        wait_done("bit_err");
        inv0 = -1; inv1 = -1; inv2 = -1;
        n_tests++;
        if (bit_err_ct_o !== 16'd2) begin
            n_fail++;
            $display("FAIL bit_err_count: got %0d required 2", bit_err_ct_o);
        end
    endtask

    task automatic test_ignored_start;
        int t;
        start_run(8'd16, 3'd1, 2'b10);
        repeat (50) @(negedge clk);
        err_period_i = 8'd1; err_mask_i = 2'b11; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        t = 0;
        while (done_o !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        n_tests++;
        if (mon_done_cnt !== 1 || mon_done_cyc !== DONE_AT) begin
            n_fail++;
            $display("FAIL ign_done: count=%0d cycle=%0d required 1 at %0d", mon_done_cnt, mon_done_cyc, DONE_AT);
        end
        n_tests++;
        if (mon_idx !== N_ENC || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ign_restart: enc=%0d busy=%b required %0d 0", mon_idx, busy_o, N_ENC);
        end
        n_tests++;
        if (inj_ct_o !== 16'd16) begin
            n_fail++;
            $display("FAIL ign_inj_count: got %0d required 16", inj_ct_o);
        end
    endtask

    task automatic test_reset_midrun;
        int t, mism;
        start_run(8'd16, 3'd1, 2'b11);
        t = 0;
        while (mon_idx < 260 && t < 400) begin
            @(negedge clk);
            t++;
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if ({enc_en_o, enc_data_o, err_inj_o, busy_o, done_o} !== 6'b0 ||
            inj_ct_o !== 16'd0 || bit_err_ct_o !== 16'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: ctrl=%b inj=%0d err=%0d required 0 0 0",
                     {enc_en_o, enc_data_o, err_inj_o, busy_o, done_o}, inj_ct_o, bit_err_ct_o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        n_tests++;
        if (mon_done_cnt !== 0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: pulses=%0d busy=%b required 0 0", mon_done_cnt, busy_o);
        end
        start_run(8'd0, 3'd0, 2'b00);
        wait_done("rerun");
        prbs_mismatch(mism);
        n_tests++;
        if (mism !== 0 || mon_done_cyc !== DONE_AT || bit_err_ct_o !== 16'd0) begin
            n_fail++;
            $display("FAIL rerun_clean: prbs_bad=%0d done_cyc=%0d err=%0d required 0 %0d 0",
                     mism, mon_done_cyc, bit_err_ct_o, DONE_AT);
        end
    endtask

    task automatic test_saturation;
        int t;
        @(negedge clk);
        s_period = 8'd1; s_burst = 3'd1; s_mask = 2'b11; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (s_inj_ct !== 4'd6) begin
            n_fail++;
            $display("FAIL sat_ramp: got %0d required 6", s_inj_ct);
        end
        repeat (16) @(negedge clk);
        n_tests++;
        if (s_inj_ct !== 4'hF) begin
            n_fail++;
            $display("FAIL sat_inj_mid: got %h required F", s_inj_ct);
        end
        t = 0;
        while (s_done !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        n_tests++;
        if (s_inj_ct !== 4'hF || s_bit_err !== 4'hF || s_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_final: inj=%h err=%h busy=%b required F F 0", s_inj_ct, s_bit_err, s_busy);
        end
    endtask

    initial begin
        test_reset;
        test_no_inject;
        test_inject("burst1", 8'd16, 3'd1, 2'b10, 0, 16);
        test_inject("burst2", 8'd16, 3'd2, 2'b11, 1, 64);
        test_inject("cont",   8'd2,  3'd4, 2'b11, 2, 526);
        test_bit_err;
        test_ignored_start;
        test_reset_midrun;
        test_saturation;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
